// File: rtl/accum_sb_pkg.sv
// Shared types and constants for the accumulator scoreboard.
// Holds the FSM state encoding, mismatch flag positions and the saturating counter helper.
package accum_sb_pkg;

  typedef enum logic [1:0] {
    SB_IDLE,
    SB_WARMUP,
    SB_CHECK,
    SB_DONE
  } sb_state_t;

  localparam int ERR_W      = 3;
  localparam int ERR_ACCUM  = 0;
  localparam int ERR_BYPASS = 1;
  localparam int ERR_PT     = 2;

  localparam logic [15:0] ERR_CNT_MAX = 16'hFFFF;

  // Error counter sticks at its maximum instead of wrapping back to a "clean" value.
  function automatic logic [15:0] sat_inc16(input logic [15:0] value);
    return (value == ERR_CNT_MAX) ? value : value + 16'd1;
  endfunction

endpackage

// File: rtl/accum_scoreboard_if.sv
// Bundle of the observed accumulator-wrapper signals plus the scoreboard verdict outputs.
// The slave side is the scoreboard; the master side is whoever drives stimulus and reads results.
interface accum_scoreboard_if #(
  parameter int ACC_W = 32,
  parameter int PT_W  = 310
);
  import accum_sb_pkg::*;

  logic             start;
  logic [ACC_W-1:0] accum_in;
  logic             accum_bypass;
  logic [ACC_W-1:0] accum_out;
  logic [ACC_W-1:0] accum_bypass_out;
  logic [PT_W-1:0]  pt_in;
  logic [PT_W-1:0]  pt_out;

  logic             busy;
  logic             done;
  logic             pass;
  logic [15:0]      err_count;
  logic [ERR_W-1:0] err_mask;
  logic [15:0]      first_err_cycle;

  modport master (
    output start, accum_in, accum_bypass, accum_out, accum_bypass_out, pt_in, pt_out,
    input  busy, done, pass, err_count, err_mask, first_err_cycle
  );

  modport slave (
    input  start, accum_in, accum_bypass, accum_out, accum_bypass_out, pt_in, pt_out,
    output busy, done, pass, err_count, err_mask, first_err_cycle
  );

endinterface

// File: rtl/sb_delay_line.sv
// Fixed-depth register pipeline used to align golden values with the DUT's latency.
// A depth of zero degenerates to a plain wire.
module sb_delay_line #(
  parameter int WIDTH = 1,
  parameter int DEPTH = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  generate
    if (DEPTH == 0) begin : g_wire
      logic unused_clk_rst;
      assign unused_clk_rst = clk ^ rst;
      assign q = d;
    end else begin : g_regs
      logic [WIDTH-1:0] stage [DEPTH];

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          for (int i = 0; i < DEPTH; i++) begin
            stage[i] <= '0;
          end
        end else begin
          stage[0] <= d;
          for (int i = 1; i < DEPTH; i++) begin
            stage[i] <= stage[i-1];
          end
        end
      end

      assign q = stage[DEPTH-1];
    end
  endgenerate

endmodule

// File: rtl/accum_scoreboard.sv
// Downstream checker for the protected accumulator wrapper: runs a golden accumulator,
// compares outputs and passthrough lanes over a fixed window and reports a verdict.
module accum_scoreboard #(
  parameter int               ACC_W      = 32,
  parameter int               PT_W       = 310,
  parameter int               LATENCY    = 1,
  parameter int               PT_LATENCY = 0,
  parameter int               NUM_CYCLES = 10,
  parameter logic [ACC_W-1:0] ACC_INIT   = '0
) (
  input logic               clk,
  input logic               rst,
  accum_scoreboard_if.slave sb
);
  import accum_sb_pkg::*;

  localparam logic [15:0] WARM_LAST  = 16'(LATENCY - 1);
  localparam logic [15:0] CHECK_LAST = 16'(NUM_CYCLES - 1);

  sb_state_t        state;
  logic [ACC_W-1:0] acc_exp;
  logic [15:0]      warm_cnt;
  logic [15:0]      idx;

  logic             busy_q;
  logic             done_q;
  logic             pass_q;
  logic [15:0]      err_count_q;
  logic [ERR_W-1:0] err_mask_q;
  logic [15:0]      first_err_q;

  logic [ACC_W-1:0] exp_out;
  logic [ACC_W-1:0] exp_byp;
  logic [PT_W-1:0]  exp_pt;
  logic [ERR_W-1:0] mism;

  // The model register is one cycle ahead of a LATENCY=1 DUT, so only LATENCY-1 extra stages.
  sb_delay_line #(
    .WIDTH (ACC_W),
    .DEPTH (LATENCY - 1)
  ) u_out_dly (
    .clk (clk),
    .rst (rst),
    .d   (acc_exp),
    .q   (exp_out)
  );

  sb_delay_line #(
    .WIDTH (PT_W),
    .DEPTH (PT_LATENCY)
  ) u_pt_dly (
    .clk (clk),
    .rst (rst),
    .d   (sb.pt_in),
    .q   (exp_pt)
  );

  // Case-inequality so an X or Z on any observed DUT output is reported as a mismatch.
  always_comb begin
    exp_byp          = sb.accum_bypass ? sb.accum_in : exp_out;
    mism             = '0;
    mism[ERR_ACCUM]  = (sb.accum_out !== exp_out);
    mism[ERR_BYPASS] = (sb.accum_bypass_out !== exp_byp);
    mism[ERR_PT]     = (sb.pt_out !== exp_pt);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= SB_IDLE;
      acc_exp     <= '0;
      warm_cnt    <= '0;
      idx         <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      pass_q      <= 1'b0;
      err_count_q <= '0;
      err_mask_q  <= '0;
      first_err_q <= ERR_CNT_MAX;
    end else begin
      case (state)
        SB_IDLE, SB_DONE: begin
          if (sb.start) begin
            state       <= SB_WARMUP;
            acc_exp     <= ACC_INIT;
            warm_cnt    <= '0;
            idx         <= '0;
            busy_q      <= 1'b1;
            done_q      <= 1'b0;
            pass_q      <= 1'b0;
            err_count_q <= '0;
            err_mask_q  <= '0;
            first_err_q <= ERR_CNT_MAX;
          end
        end

        SB_WARMUP: begin
          acc_exp <= acc_exp + sb.accum_in;
          if (warm_cnt == WARM_LAST) begin
            state <= SB_CHECK;
          end else begin
            warm_cnt <= warm_cnt + 16'd1;
          end
        end

        SB_CHECK: begin
          acc_exp <= acc_exp + sb.accum_in;
          // A non-zero count is the "already failed" marker because it can never return to zero.
          if (|mism) begin
            err_count_q <= sat_inc16(err_count_q);
            err_mask_q  <= err_mask_q | mism;
            if (err_count_q == '0) begin
              first_err_q <= idx;
            end
          end
          if (idx == CHECK_LAST) begin
            state  <= SB_DONE;
            busy_q <= 1'b0;
            done_q <= 1'b1;
            pass_q <= (err_count_q == '0) && (mism == '0);
          end else begin
            idx <= idx + 16'd1;
          end
        end

        default: begin
          state  <= SB_IDLE;
          busy_q <= 1'b0;
          done_q <= 1'b0;
        end
      endcase
    end
  end

  assign sb.busy            = busy_q;
  assign sb.done            = done_q;
  assign sb.pass            = pass_q;
  assign sb.err_count       = err_count_q;
  assign sb.err_mask        = err_mask_q;
  assign sb.first_err_cycle = first_err_q;

endmodule

// File: tb/tb_accum_scoreboard.sv
// Self-checking bench: an ideal accumulator wrapper is emulated with optional fault injection,
// and the scoreboard verdict is compared every cycle against a run-level reference model.
module tb_accum_scoreboard;
  localparam int          ACC_W = 32;
  localparam int          PT_W  = 310;
  localparam int          LAT   = 1;
  localparam int          NUM   = 10;
  localparam logic [31:0] INIT1 = 32'hFFFF_FFF0;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic            start_v = 1'b0;
  int              sel     = 0;
  logic [31:0]     in_v    = '0;
  logic            byp_v   = 1'b0;
  logic [PT_W-1:0] pt_v    = '0;
  logic [PT_W-1:0] pt_flip = '0;
  logic            cor_acc = 1'b0;
  logic            cor_byp = 1'b0;
  logic [31:0]     emu_acc0 = '0;
  logic [31:0]     emu_acc1 = '0;

  int in_mode  = 0;
  int byp_from = NUM;
  int pt_bit   = 200;
  bit err_acc [NUM];
  bit err_byp [NUM];
  bit err_pt  [NUM];

  accum_scoreboard_if #(.ACC_W(ACC_W), .PT_W(PT_W)) if0 ();
  accum_scoreboard_if #(.ACC_W(ACC_W), .PT_W(PT_W)) if1 ();

  accum_scoreboard #(
    .ACC_W(ACC_W), .PT_W(PT_W), .LATENCY(LAT), .PT_LATENCY(0),
    .NUM_CYCLES(NUM), .ACC_INIT(32'h0)
  ) u_dut (
    .clk (clk),
    .rst (rst),
    .sb  (if0.slave)
  );

  accum_scoreboard #(
    .ACC_W(ACC_W), .PT_W(PT_W), .LATENCY(LAT), .PT_LATENCY(0),
    .NUM_CYCLES(NUM), .ACC_INIT(INIT1)
  ) u_dut_wrap (
    .clk (clk),
    .rst (rst),
    .sb  (if1.slave)
  );

  // Emulated wrapper outputs, with injected faults layered on top of the ideal values.
  assign if0.start            = start_v && (sel == 0);
  assign if0.accum_in         = in_v;
  assign if0.accum_bypass     = byp_v;
  assign if0.accum_out        = emu_acc0 + {31'd0, cor_acc};
  assign if0.accum_bypass_out = (byp_v ? in_v : emu_acc0) ^ {31'd0, cor_byp};
  assign if0.pt_in            = pt_v;
  assign if0.pt_out           = pt_v ^ pt_flip;

  assign if1.start            = start_v && (sel == 1);
  assign if1.accum_in         = in_v;
  assign if1.accum_bypass     = byp_v;
  assign if1.accum_out        = emu_acc1 + {31'd0, cor_acc};
  assign if1.accum_bypass_out = (byp_v ? in_v : emu_acc1) ^ {31'd0, cor_byp};
  assign if1.pt_in            = pt_v;
  assign if1.pt_out           = pt_v ^ pt_flip;

  // Reference verdict: position within the run, running golden sum, and the error tally.
  int          m_pos   = 0;
  bit          m_busy  = 1'b0;
  bit          m_done  = 1'b0;
  bit          m_pass  = 1'b0;
  logic [15:0] m_cnt   = '0;
  logic [15:0] m_first = 16'hFFFF;
  logic [2:0]  m_mask  = '0;
  logic [31:0] m_acc   = '0;
  logic [2:0]  diff;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_pos = 0; m_busy = 0; m_done = 0; m_pass = 0;
      m_cnt = '0; m_first = 16'hFFFF; m_mask = '0; m_acc = '0;
      emu_acc0 <= '0;
      emu_acc1 <= '0;
    end else begin
      emu_acc1 <= if1.start ? INIT1 : emu_acc1 + in_v;
      emu_acc0 <= (if0.start && !m_busy) ? 32'h0 : emu_acc0 + in_v;
      if (m_busy) begin
        if (m_pos >= LAT) begin
          diff[0] = (if0.accum_out !== m_acc);
          diff[1] = (if0.accum_bypass_out !== (byp_v ? in_v : m_acc));
          diff[2] = (if0.pt_out !== pt_v);
          if (diff != 3'b000) begin
            if (m_cnt == 16'd0) m_first = 16'(m_pos - LAT);
            if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
            m_mask = m_mask | diff;
          end
        end
        m_acc = m_acc + in_v;
        m_pos = m_pos + 1;
        if (m_pos == LAT + NUM) begin
          m_busy = 0; m_done = 1; m_pass = (m_cnt == 16'd0);
        end
      end else if (if0.start) begin
        m_pos = 0; m_busy = 1; m_done = 0; m_pass = 0;
        m_cnt = '0; m_first = 16'hFFFF; m_mask = '0; m_acc = '0;
      end
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    checkOutput("busy",      {31'd0, if0.busy},       {31'd0, m_busy});
    checkOutput("done",      {31'd0, if0.done},       {31'd0, m_done});
    checkOutput("pass",      {31'd0, if0.pass},       {31'd0, m_pass});
    checkOutput("err_count", {16'd0, if0.err_count},  {16'd0, m_cnt});
    checkOutput("err_mask",  {29'd0, if0.err_mask},   {29'd0, m_mask});
    checkOutput("first_err", {16'd0, if0.first_err_cycle}, {16'd0, m_first});
  end

  task automatic idleInputs();
    start_v = 1'b0; in_v = '0; byp_v = 1'b0;
    cor_acc = 1'b0; cor_byp = 1'b0; pt_flip = '0;
  endtask

  task automatic clearErrs();
    for (int i = 0; i < NUM; i++) begin
      err_acc[i] = 1'b0; err_byp[i] = 1'b0; err_pt[i] = 1'b0;
    end
  endtask

  task automatic driveCycle(input int s, input int k);
    logic [319:0] wide;
    case (in_mode)
      0:       in_v = 32'(5 * s);
      1:       in_v = 32'd16;
      default: in_v = $urandom;
    endcase
    if (byp_from < 0) byp_v = 1'($urandom_range(0, 1));
    else              byp_v = (k >= 0) && (k >= byp_from);
    for (int w = 0; w < 10; w++) wide[w*32 +: 32] = $urandom;
    pt_v    = wide[PT_W-1:0];
    cor_acc = 1'b0; cor_byp = 1'b0; pt_flip = '0;
    if (k >= 0) begin
      cor_acc = err_acc[k];
      cor_byp = err_byp[k];
      if (err_pt[k]) pt_flip[pt_bit] = 1'b1;
    end
  endtask

  // One run: start pulse, LAT warmup cycle, NUM check cycles, then one idle cycle to see done.
  task automatic applyStimulus(input int sel_i, input int byp_from_i, input int rst_at, input bit poke);
    sel = sel_i; byp_from = byp_from_i;
    @(posedge clk); #1;
    start_v = 1'b1; driveCycle(0, -1);
    @(posedge clk); #1;
    start_v = 1'b0; driveCycle(1, -1);
    for (int k = 0; k < NUM; k++) begin
      @(posedge clk); #1;
      if (k == rst_at) begin
        rst = 1'b1; idleInputs();
        @(negedge clk);
        @(posedge clk); #1;
        rst = 1'b0;
        return;
      end
      start_v = poke && (k == 2);
      driveCycle(k + 2, k);
      if (k == NUM - 1)
        checkOutput("done_early", {31'd0, (sel_i == 1) ? if1.done : if0.done}, 32'd0);
    end
    @(posedge clk); #1;
    idleInputs();
  endtask

  initial begin
    clearErrs();
    idleInputs();
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    checkOutput("rst_busy",  {31'd0, if0.busy},            32'd0);
    checkOutput("rst_done",  {31'd0, if0.done},            32'd0);
    checkOutput("rst_count", {16'd0, if0.err_count},       32'd0);
    checkOutput("rst_first", {16'd0, if0.first_err_cycle}, 32'h0000_FFFF);

    $display("[TB] clean run, ramp input");
    in_mode = 0;
    applyStimulus(0, NUM, -1, 1'b0);
    checkOutput("t1_done",  {31'd0, if0.done},            32'd1);
    checkOutput("t1_pass",  {31'd0, if0.pass},            32'd1);
    checkOutput("t1_count", {16'd0, if0.err_count},       32'd0);
    checkOutput("t1_first", {16'd0, if0.first_err_cycle}, 32'h0000_FFFF);

    $display("[TB] bypass from check cycle 5");
    applyStimulus(0, 5, -1, 1'b0);
    checkOutput("t2_pass",  {31'd0, if0.pass},      32'd1);
    checkOutput("t2_count", {16'd0, if0.err_count}, 32'd0);

    $display("[TB] accum_out corrupted at cycles 3 and 7");
    err_acc[3] = 1'b1; err_acc[7] = 1'b1;
    applyStimulus(0, NUM, -1, 1'b0);
    clearErrs();
    checkOutput("t3_count", {16'd0, if0.err_count},       32'd2);
    checkOutput("t3_mask",  {29'd0, if0.err_mask},        32'b001);
    checkOutput("t3_first", {16'd0, if0.first_err_cycle}, 32'd3);
    checkOutput("t3_pass",  {31'd0, if0.pass},            32'd0);

    $display("[TB] pt bit 200 and bypass error at cycle 0");
    pt_bit = 200; err_pt[0] = 1'b1; err_byp[0] = 1'b1;
    applyStimulus(0, NUM, -1, 1'b0);
    clearErrs();
    checkOutput("t4_count", {16'd0, if0.err_count},       32'd1);
    checkOutput("t4_mask",  {29'd0, if0.err_mask},        32'b110);
    checkOutput("t4_first", {16'd0, if0.first_err_cycle}, 32'd0);

    $display("[TB] wrapping initial value");
    in_mode = 1;
    applyStimulus(1, NUM, -1, 1'b0);
    checkOutput("t5_done",  {31'd0, if1.done},            32'd1);
    checkOutput("t5_pass",  {31'd0, if1.pass},            32'd1);
    checkOutput("t5_count", {16'd0, if1.err_count},       32'd0);
    checkOutput("t5_first", {16'd0, if1.first_err_cycle}, 32'h0000_FFFF);

    $display("[TB] reset mid-run, then clean run with ignored start");
    in_mode = 2;
    applyStimulus(0, -1, 4, 1'b0);
    checkOutput("t6_busy",  {31'd0, if0.busy},      32'd0);
    checkOutput("t6_done",  {31'd0, if0.done},      32'd0);
    checkOutput("t6_count", {16'd0, if0.err_count}, 32'd0);
    applyStimulus(0, -1, -1, 1'b1);
    checkOutput("t6_done2", {31'd0, if0.done}, 32'd1);
    checkOutput("t6_pass2", {31'd0, if0.pass}, 32'd1);

    $display("[TB] randomized runs");
    for (int r = 0; r < 8; r++) begin
      for (int i = 0; i < NUM; i++) begin
        err_acc[i] = ($urandom_range(0, 5) == 0);
        err_byp[i] = ($urandom_range(0, 5) == 0);
        err_pt[i]  = ($urandom_range(0, 7) == 0);
      end
      pt_bit = $urandom_range(0, PT_W - 1);
      repeat ($urandom_range(0, 3)) @(posedge clk);
      applyStimulus(0, -1, -1, (r % 2) == 1);
      clearErrs();
    end

    repeat (2) @(posedge clk);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
